ahb_lite_master: RTL and testbench

- Synthesizable AHB-lite initiator. It is the RTL counterpart of the team's `ahb_slave` and replaces the behavioural master BFM in block-level integration.
- Accepts write/read commands on a valid/ready interface, buffers them in a small FIFO, and issues single NONSEQ transfers.
- Transfers are fully pipelined: back-to-back transfers overlap address and data phases, giving one transfer per cycle when hready=1.
- Returns a one-cycle response pulse per completed transfer, carrying read data for reads.

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahb_cmd_fifo.sv | 61 ++++++
 rtl/ahb_lite_master.sv | 116 +++++++++++
 tb/tb_ahb_lite_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite types and default widths for the master and its command FIFO.
package ahb_pkg;

  localparam int HTRANS_W   = 2;
  localparam int AHB_ADDR_W = 8;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [HTRANS_W-1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO; the head entry is a registered output, which lets it
// drive the AHB address phase directly.
module ahb_cmd_fifo
  import ahb_pkg::*;
#(
  parameter int  CMD_DEPTH = 2,
  parameter type entry_t   = cmd_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  entry_t           mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(CMD_DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer arithmetic wraps naturally because CMD_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-lite initiator: queued commands become single NONSEQ transfers with
// overlapped address/data phases and a one-cycle response pulse per transfer.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W    = AHB_ADDR_W,
  parameter int DATA_W    = AHB_DATA_W,
  parameter int CMD_DEPTH = 2
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic [HTRANS_W-1:0] htrans,
  output logic                hwrite,
  output logic [ADDR_W-1:0]   haddr,
  output logic [DATA_W-1:0]   hwdata,
  input  logic                hready,
  input  logic [DATA_W-1:0]   hrdata,
  output logic                rsp_valid,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_p_t;

  cmd_p_t  push_data, head;
  logic    fifo_empty, fifo_full, push, pop;
  htrans_t htrans_w;

  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign cmd_ready = !fifo_full && !hreset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = hready && !fifo_empty;
  assign push_data = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  ahb_cmd_fifo #(
    .CMD_DEPTH (CMD_DEPTH),
    .entry_t   (cmd_p_t)
  ) u_cmd_fifo (
    .clk_i       (hclk),
    .rst_i       (hreset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Address phase is the FIFO head itself, so a stalled head holds the bus stable.
  assign htrans_w = fifo_empty ? IDLE : NONSEQ;
  assign htrans   = htrans_w;
  assign haddr    = fifo_empty ? '0 : head.addr;
  assign hwrite   = fifo_empty ? 1'b0 : head.write;

  assign hwdata    = (d_valid_q && d_write_q) ? d_wdata_q : '0;
  assign busy      = !fifo_empty || d_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    if (hready) begin
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = d_write_q;
        rsp_rdata_d = d_write_q ? '0 : hrdata;
      end
      d_valid_d = !fifo_empty;
      if (!fifo_empty) begin
        d_write_d = head.write;
        d_wdata_d = head.wdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench: a memory-array reference predicts every response in command
// order; a simple pipelined slave memory sits on the bus.
module tb_ahb_lite_master;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, hrdata;
  logic          hready;
  logic          rsp_valid, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  int   hready_mode = 0;   // 0: low, 1: high, 2: random
  logic rnd_ready = 1'b1;
  assign hready = (hready_mode == 2) ? rnd_ready : (hready_mode == 1);

  always #5 hclk = ~hclk;

  ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(2)) dut (
    .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .rsp_valid(rsp_valid),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always @(negedge hclk) rnd_ready = ($urandom_range(0, 3) != 0);

  // Bus slave memory with a preload port for setting contents from the bench.
  logic [DW-1:0] smem [256];
  logic          s_dvalid, s_dwrite;
  logic [AW-1:0] s_daddr;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge hclk) begin
    if (pre_en) smem[pre_addr] <= pre_data;
    if (hreset) s_dvalid <= 1'b0;
    else if (hready) begin
      if (s_dvalid && s_dwrite) smem[s_daddr] <= hwdata;
      s_dvalid <= (htrans == 2'b10);
      s_daddr  <= haddr;
      s_dwrite <= hwrite;
    end
  end
  assign hrdata = (s_dvalid && !s_dwrite) ? smem[s_daddr] : 32'hdead_beef;

  logic last_hready, last_rst;
  always @(posedge hclk) begin
    last_hready <= hready;
    last_rst    <= hreset;
  end

  // Reference: transfers complete in command order, so memory contents at
  // acceptance time give the read data.
  typedef struct { logic wr; logic [DW-1:0] rdata; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [32];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic [1:0]    p_htrans = 2'b00;
  logic          p_hwrite = 1'b0;
  logic [AW-1:0] p_haddr = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      chk("rsp_gated", 32'(rsp_valid & (!last_hready | last_rst)), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(e.wr));
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
      if (!last_hready && !last_rst && p_htrans == 2'b10) begin
        chk("hold_htrans", 32'(htrans), 32'(p_htrans));
        chk("hold_haddr", 32'(haddr), 32'(p_haddr));
        chk("hold_hwrite", 32'(hwrite), 32'(p_hwrite));
      end
      p_htrans = htrans;
      p_haddr  = haddr;
      p_hwrite = hwrite;
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    exp_t e;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && t < 100) begin
      @(negedge hclk);
      t++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.wr    = wr;
    e.rdata = wr ? '0 : ref_mem[a[4:0]];
    exp_q.push_back(e);
    if (wr) ref_mem[a[4:0]] = d;
    @(negedge hclk);
    cmd_valid = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a[4:0]] = d;
    @(negedge hclk);
    pre_en = 1'b0;
  endtask

  initial begin
    int cnt;
    @(negedge hclk);
    for (int i = 0; i < 32; i++) preload(AW'(i), $urandom);

    // Reset state
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_haddr", 32'(haddr), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_write", 32'(rsp_write), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    hreset = 1'b0;
    @(negedge hclk);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Single write
    hready_mode = 1;
    push_cmd(1'b1, 8'h0d, 32'h5a5a_5a5a);
    chk("wr_htrans", 32'(htrans), 32'd2);
    chk("wr_haddr", 32'(haddr), 32'h0d);
    chk("wr_hwrite", 32'(hwrite), 32'd1);
    @(negedge hclk);
    chk("wr_hwdata", hwdata, 32'h5a5a_5a5a);
    chk("wr_htrans_idle", 32'(htrans), 32'd0);
    chk("wr_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge hclk);
    chk("wr_rsp", 32'(rsp_valid), 32'd1);
    @(negedge hclk);
    chk("wr_rsp_once", 32'(rsp_valid), 32'd0);
    chk("wr_busy", 32'(busy), 32'd0);
    chk("wr_mem", smem[8'h0d], 32'h5a5a_5a5a);

    // Single read
    preload(8'h1d, 32'h5a5a_5a5a);
    push_cmd(1'b0, 8'h1d, 32'h0);
    chk("rd_htrans", 32'(htrans), 32'd2);
    @(negedge hclk);
    chk("rd_hwdata_zero", hwdata, 32'd0);
    @(negedge hclk);
    chk("rd_rsp", 32'(rsp_valid), 32'd1);
    chk("rd_rdata", rsp_rdata, 32'h5a5a_5a5a);

    // Back-to-back write then read of the same address
    push_cmd(1'b1, 8'h08, 32'h55);
    push_cmd(1'b0, 8'h08, 32'h0);
    chk("b2b_htrans", 32'(htrans), 32'd2);
    chk("b2b_hwrite", 32'(hwrite), 32'd0);
    chk("b2b_hwdata", hwdata, 32'h55);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      if (rsp_valid) cnt++;
    end
    chk("b2b_rsp_count", 32'(cnt), 32'd2);
    chk("b2b_mem", smem[8'h08], 32'h55);

    // Wait states during a read data phase
    preload(8'h10, 32'hffff_ff00);
    push_cmd(1'b0, 8'h10, 32'h0);
    @(negedge hclk);
    hready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      chk("ws_no_rsp", 32'(rsp_valid), 32'd0);
      chk("ws_htrans", 32'(htrans), 32'd0);
      chk("ws_busy", 32'(busy), 32'd1);
    end
    hready_mode = 1;
    @(negedge hclk);
    chk("ws_rsp", 32'(rsp_valid), 32'd1);
    chk("ws_rdata", rsp_rdata, 32'hffff_ff00);

    // FIFO full, then reset discards everything
    @(negedge hclk);
    hready_mode = 0;
    push_cmd(1'b0, 8'h01, 32'h0);
    push_cmd(1'b0, 8'h02, 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03;
    chk("full_ready", 32'(cmd_ready), 32'd0);
    @(negedge hclk);
    chk("full_ready_hold", 32'(cmd_ready), 32'd0);
    chk("full_haddr", 32'(haddr), 32'h01);
    chk("full_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    hreset = 1'b1;
    exp_q.delete();
    @(negedge hclk);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mid_htrans", 32'(htrans), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    hreset = 1'b0;
    @(negedge hclk);

    // Randomized traffic with random wait states
    hready_mode = 2;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge hclk);
      push_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
    end
    hready_mode = 1;
    cnt = 0;
    while ((exp_q.size() != 0 || busy) && cnt < 200) begin
      @(negedge hclk);
      cnt++;
    end
    @(negedge hclk);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) chk("final_mem", smem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
